// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronizes rx, finds the start bit, and steers the
// shared baud generator to sample data, optional parity and stop at mid-bit.
module uart_rx_ctrl #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 enable_clk,
  output logic                 baud_en,
  output logic                 start_bod,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 par_err,
  output logic                 busy
);

  localparam int   CNT_W   = $clog2(DATA_BITS + 1);
  localparam logic ODD_BIT = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Synchronizer chain; flops reset high so reset never looks like a start edge
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_s;
  logic                   rx_prev_reg;
  logic                   start_edge;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b1;
          else        sync_reg[gi] <= rx;
        end
      end else begin : g_rest
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b1;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign rx_s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_prev_reg <= 1'b1;
    else        rx_prev_reg <= rx_s;
  end

  // Tracking rx_prev in every state means a line left low needs a fresh 1->0 edge
  assign start_edge = rx_prev_reg & ~rx_s;

  state_t                 state_reg, state_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   perr_flag_reg, perr_flag_next;
  logic                   baud_en_reg, baud_en_next;
  logic                   start_bod_reg, start_bod_next;
  logic [DATA_BITS-1:0]   data_out_reg, data_out_next;
  logic                   valid_reg, valid_next;
  logic                   frame_err_reg, frame_err_next;
  logic                   par_err_reg, par_err_next;
  logic                   busy_reg, busy_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      perr_flag_reg <= 1'b0;
      baud_en_reg   <= 1'b0;
      start_bod_reg <= 1'b1;
      data_out_reg  <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      par_err_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      cnt_reg       <= cnt_next;
      perr_flag_reg <= perr_flag_next;
      baud_en_reg   <= baud_en_next;
      start_bod_reg <= start_bod_next;
      data_out_reg  <= data_out_next;
      valid_reg     <= valid_next;
      frame_err_reg <= frame_err_next;
      par_err_reg   <= par_err_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    cnt_next       = cnt_reg;
    perr_flag_next = perr_flag_reg;
    baud_en_next   = baud_en_reg;
    start_bod_next = start_bod_reg;
    data_out_next  = data_out_reg;
    valid_next     = 1'b0;
    frame_err_next = 1'b0;
    par_err_next   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        baud_en_next   = 1'b0;
        start_bod_next = 1'b1;
        if (start_edge) begin
          state_next     = START;
          baud_en_next   = 1'b1;
          perr_flag_next = 1'b0;
        end
      end

      START: begin
        if (enable_clk) begin
          if (!rx_s) begin
            state_next     = DATA;
            start_bod_next = 1'b0;
            cnt_next       = '0;
          end else begin
            state_next     = IDLE;
            baud_en_next   = 1'b0;
            start_bod_next = 1'b1;
          end
        end
      end

      DATA: begin
        if (enable_clk) begin
          shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
          cnt_next   = cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(DATA_BITS - 1))
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end

      PARITY: begin
        if (enable_clk) begin
          perr_flag_next = (^shift_reg) ^ rx_s ^ ODD_BIT;
          state_next     = STOP;
        end
      end

      STOP: begin
        if (enable_clk) begin
          data_out_next  = shift_reg;
          if (rx_s) begin
            valid_next   = ~perr_flag_reg;
            par_err_next = perr_flag_reg;
          end else begin
            frame_err_next = 1'b1;
            par_err_next   = perr_flag_reg;
          end
          state_next     = IDLE;
          baud_en_next   = 1'b0;
          start_bod_next = 1'b1;
        end
      end

      default: begin
        state_next     = IDLE;
        baud_en_next   = 1'b0;
        start_bod_next = 1'b1;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign baud_en    = baud_en_reg;
  assign start_bod  = start_bod_reg;
  assign data_out   = data_out_reg;
  assign data_valid = valid_reg;
  assign frame_err  = frame_err_reg;
  assign par_err    = par_err_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: an 8N1 and an 8E1 instance, each paired with a small
// behavioural baud generator, driven by directed and random frames.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int   BIT  = 32;
  localparam int   HALF = 16;
  localparam logic PODD = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_a = 1'b1, rx_p = 1'b1;
  logic       tick_a, tick_p;
  logic       baud_en_a, baud_en_p, start_bod_a, start_bod_p;
  logic [7:0] data_out_a, data_out_p;
  logic       data_valid_a, data_valid_p, frame_err_a, frame_err_p;
  logic       par_err_a, par_err_p, busy_a, busy_p;
  int         bcnt_a, bcnt_p;

  int compared = 0;
  int mismatched = 0;
  int nv[2]    = '{0, 0};
  int nf[2]    = '{0, 0};
  int np[2]    = '{0, 0};
  int nbs[2]   = '{0, 0};
  int novl[2]  = '{0, 0};
  int nbusy[2] = '{0, 0};
  logic [7:0] last_data[2];

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .enable_clk(tick_a),
    .baud_en(baud_en_a), .start_bod(start_bod_a), .data_out(data_out_a),
    .data_valid(data_valid_a), .frame_err(frame_err_a), .par_err(par_err_a), .busy(busy_a)
  );

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .SYNC_STAGES(2)) dut_p (
    .clk(clk), .rst_n(rst_n), .rx(rx_p), .enable_clk(tick_p),
    .baud_en(baud_en_p), .start_bod(start_bod_p), .data_out(data_out_p),
    .data_valid(data_valid_p), .frame_err(frame_err_p), .par_err(par_err_p), .busy(busy_p)
  );

  // Baud generator: cleared while disabled, half or full terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin bcnt_a <= 0; tick_a <= 1'b0; end
    else if (!baud_en_a) begin bcnt_a <= 0; tick_a <= 1'b0; end
    else if (bcnt_a == (start_bod_a ? HALF - 1 : BIT - 1)) begin bcnt_a <= 0; tick_a <= 1'b1; end
    else begin bcnt_a <= bcnt_a + 1; tick_a <= 1'b0; end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin bcnt_p <= 0; tick_p <= 1'b0; end
    else if (!baud_en_p) begin bcnt_p <= 0; tick_p <= 1'b0; end
    else if (bcnt_p == (start_bod_p ? HALF - 1 : BIT - 1)) begin bcnt_p <= 0; tick_p <= 1'b1; end
    else begin bcnt_p <= bcnt_p + 1; tick_p <= 1'b0; end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid_a) nv[0]++;
      if (frame_err_a)  nf[0]++;
      if (par_err_a)    np[0]++;
      if ((data_valid_a || frame_err_a || par_err_a) && busy_a) nbs[0]++;
      if (data_valid_a && (frame_err_a || par_err_a)) novl[0]++;
      if (busy_a) nbusy[0]++;
      if (data_valid_p) nv[1]++;
      if (frame_err_p)  nf[1]++;
      if (par_err_p)    np[1]++;
      if ((data_valid_p || frame_err_p || par_err_p) && busy_p) nbs[1]++;
      if (data_valid_p && (frame_err_p || par_err_p)) novl[1]++;
      if (busy_p) nbusy[1]++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic v, input int n);
    if (w == 0) rx_a = v;
    else        rx_p = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int w, input logic [7:0] d, input logic pbit,
                            input logic stop, input bit probe);
    if (probe) begin
      drive(w, 1'b0, 4);
      chk("t1_baud_en_rise", baud_en_a, 1'b1);
      chk("t1_busy_rise", busy_a, 1'b1);
      chk("t1_start_bod_half", start_bod_a, 1'b1);
      drive(w, 1'b0, 22);
      chk("t1_start_bod_fall", start_bod_a, 1'b0);
      drive(w, 1'b0, BIT - 26);
    end else begin
      drive(w, 1'b0, BIT);
    end
    for (int i = 0; i < 8; i++) drive(w, d[i], BIT);
    if (w == 1) drive(w, pbit, BIT);
    drive(w, stop, BIT);
  endtask

  task automatic do_frame(input string tag, input int w, input logic [7:0] d, input logic pbit,
                          input logic stop, input int gap, input bit probe);
    int   v0, f0, p0, b0, o0;
    logic perr;
    v0 = nv[w]; f0 = nf[w]; p0 = np[w]; b0 = nbs[w]; o0 = novl[w];
    send_frame(w, d, pbit, stop, probe);
    if (gap > 0) drive(w, 1'b1, gap);
    perr = (w == 1) ? ((^d) ^ pbit ^ PODD) : 1'b0;
    last_data[w] = d;
    chk($sformatf("%s_valid d=%02h", tag, d), nv[w] - v0, {31'b0, stop & ~perr});
    chk($sformatf("%s_frame_err d=%02h", tag, d), nf[w] - f0, {31'b0, ~stop});
    chk($sformatf("%s_par_err d=%02h", tag, d), np[w] - p0, {31'b0, perr});
    chk($sformatf("%s_data_out", tag), (w == 1) ? data_out_p : data_out_a, d);
    chk($sformatf("%s_busy_at_strobe", tag), nbs[w] - b0, 0);
    chk($sformatf("%s_strobe_overlap", tag), novl[w] - o0, 0);
  endtask

  initial begin
    int   v0, f0, p0, b0;
    logic [7:0] d;
    logic s, pb;
    int   gap;

    last_data[0] = 8'h00;
    last_data[1] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_baud_en", baud_en_a, 1'b0);
    chk("rst_start_bod", start_bod_a, 1'b1);
    chk("rst_data_out", data_out_a, 8'h00);
    chk("rst_strobes", {data_valid_a, frame_err_a, par_err_a}, 3'b000);
    chk("rst_busy", busy_a, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: 8N1 0xA5 with timing probes
    do_frame("t1", 0, 8'hA5, 1'b0, 1'b1, BIT, 1'b1);
    chk("t1_busy_after", busy_a, 1'b0);

    // 2: short low glitch is rejected at the half-bit sample
    v0 = nv[0]; f0 = nf[0]; p0 = np[0];
    drive(0, 1'b0, 4);
    chk("t2_busy_in_start", busy_a, 1'b1);
    drive(0, 1'b0, 6);
    drive(0, 1'b1, 30);
    chk("t2_busy_back_idle", busy_a, 1'b0);
    chk("t2_baud_en_off", baud_en_a, 1'b0);
    chk("t2_start_bod", start_bod_a, 1'b1);
    chk("t2_no_strobes", (nv[0] - v0) + (nf[0] - f0) + (np[0] - p0), 0);
    chk("t2_data_out_held", data_out_a, last_data[0]);
    drive(0, 1'b1, BIT);

    // 3: framing error, line held low, then recovery
    do_frame("t3_bad", 0, 8'h3C, 1'b0, 1'b0, 0, 1'b0);
    b0 = nbusy[0];
    drive(0, 1'b0, 3 * BIT);
    chk("t3_no_start_while_low", nbusy[0] - b0, 0);
    drive(0, 1'b1, BIT);
    do_frame("t3_good", 0, 8'h11, 1'b0, 1'b1, BIT, 1'b0);

    // 4: even parity
    drive(1, 1'b1, BIT);
    do_frame("t4_par_ok", 1, 8'h07, 1'b1, 1'b1, BIT, 1'b0);
    do_frame("t4_par_bad", 1, 8'h07, 1'b0, 1'b1, BIT, 1'b0);

    // 5: reset during data bit 4 of 0xF0
    v0 = nv[0]; f0 = nf[0]; p0 = np[0];
    drive(0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(0, 1'b0, BIT);
    drive(0, 1'b1, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_baud_en", baud_en_a, 1'b0);
    chk("t5_async_busy", busy_a, 1'b0);
    chk("t5_async_start_bod", start_bod_a, 1'b1);
    chk("t5_async_data_out", data_out_a, 8'h00);
    chk("t5_async_strobes", {data_valid_a, frame_err_a, par_err_a}, 3'b000);
    last_data[0] = 8'h00;
    last_data[1] = 8'h00;
    @(negedge clk);
    drive(0, 1'b1, 3);
    rst_n = 1'b1;
    drive(0, 1'b1, 2 * BIT);
    chk("t5_no_strobe", (nv[0] - v0) + (nf[0] - f0) + (np[0] - p0), 0);
    do_frame("t5_after", 0, 8'h55, 1'b0, 1'b1, BIT, 1'b0);

    // 6: back-to-back frames
    do_frame("t6_first", 0, 8'h00, 1'b0, 1'b1, 0, 1'b0);
    do_frame("t6_second", 0, 8'hFF, 1'b0, 1'b1, BIT, 1'b0);

    // Random 8N1 frames with occasional bad stop bits and back-to-back gaps
    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom_range(0, 255));
      s   = ($urandom_range(0, 3) != 0);
      gap = s ? $urandom_range(0, 40) : 4 + $urandom_range(0, 40);
      do_frame("rnd_8n1", 0, d, 1'b0, s, gap, 1'b0);
    end

    // Random 8E1 frames with random parity and stop bits
    for (int n = 0; n < 16; n++) begin
      d   = 8'($urandom_range(0, 255));
      pb  = 1'($urandom_range(0, 1));
      s   = ($urandom_range(0, 3) != 0);
      gap = s ? $urandom_range(0, 40) : 4 + $urandom_range(0, 40);
      do_frame("rnd_8e1", 1, d, pb, s, gap, 1'b0);
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART. Drives the shared baud generator's enable (`baud_en`) and half-period select (`start_bod`), and consumes its `enable_clk` tick.
- Sits between the raw `rx` pin and the byte-level consumer. Detects the start bit, re-centres on it using a half-bit period, then samples data, optional parity and stop bits at full-bit intervals.
- Emits each received byte with a one-cycle valid strobe and error flags.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8), sent LSB first.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only when PARITY_EN=1).
- SYNC_STAGES, 2, flip-flop stages in the `rx` synchronizer (minimum 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  asynchronous serial line; idles high.
- enable_clk  input  1  one-cycle tick from the baud generator.
- baud_en  output  1  enable to the baud generator; 0 holds its counter cleared.
- start_bod  output  1  1 = baud generator uses the half-period terminal count.
- data_out  output  DATA_BITS  last received data word.
- data_valid  output  1  one-cycle strobe: `data_out` updated and the frame had no errors.
- frame_err  output  1  one-cycle strobe: stop bit sampled as 0.
- par_err  output  1  one-cycle strobe: parity mismatch.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset:
  - One clock, `clk`. Reset is asynchronous and active-low on `rst_n`.
  - Reset values: `baud_en`=0, `start_bod`=1, `data_out`=0, `data_valid`=0, `frame_err`=0, `par_err`=0, `busy`=0.
  - Reset values for internal state: synchronizer flops=1, state=IDLE, shift register=0, bit counter=0.
- `rx` synchronizer:
  - `rx` passes through SYNC_STAGES flip-flops to give `rx_s`.
  - `rx_prev` holds `rx_s` delayed by one cycle.
  - A start edge is `rx_prev`=1 and `rx_s`=0.
- Registered outputs: all outputs are registered and change on the same edge as the state transition that causes them.
- `enable_clk` is ignored in IDLE.
- State machine:
  - IDLE: `baud_en`=0, `start_bod`=1. On a start edge, go to START with `baud_en`=1 and `start_bod`=1.
  - START: on a tick, sample `rx_s`.
    - If 0: go to DATA, set `start_bod`=0, clear the bit counter.
    - If 1 (false start): go to IDLE with `baud_en`=0.
  - DATA: on each tick, shift `rx_s` into the MSB of the shift register (LSB-first reception) and increment the counter. After the DATA_BITS-th tick, go to PARITY if PARITY_EN=1, else go to STOP.
  - PARITY: on a tick, compute the XOR of the data bits and the parity bit, plus PARITY_ODD. A nonzero result latches an internal parity-error flag. Then go to STOP.
  - STOP: on a tick, load `data_out` from the shift register unconditionally, then:
    - If `rx_s`=1 and no parity error: pulse `data_valid`.
    - If `rx_s`=1 and parity error: pulse `par_err`.
    - If `rx_s`=0: pulse `frame_err`, and also pulse `par_err` if the parity flag is set.
    - In all cases go to IDLE with `baud_en`=0 and `start_bod`=1.
- Strobes: `data_valid`, `frame_err` and `par_err` are high for exactly one cycle. At most one of `data_valid` and the error strobes is high in any cycle.
- Break or low line after STOP: a new frame needs a fresh 1→0 edge. A line held low after a framing error never starts a frame until `rx_s` has been seen high.
- Back-to-back frames: a start edge arriving on the cycle after STOP exits is accepted. Sampling at mid stop bit leaves half a bit of margin.
- Reset mid-frame: everything returns to reset values immediately and no strobe is emitted. `baud_en` dropping clears the baud generator counter.
- `data_out` holds its value between frames.

Test Plan:
All scenarios: CLOCK_RATE=100 MHz, BAUD_RATE=115200, baud generator instantiated alongside (868 clocks per bit, 434 for the half bit).
1. 8N1 frame 0xA5 driven on `rx` → `baud_en` rises 1 cycle after the synchronized edge; `start_bod` falls at the START tick; `data_out`=0xA5 with a single-cycle `data_valid` ~9.5 bit times after the edge; `busy` falls the same cycle.
2. `rx` low glitch of 100 clocks → FSM enters START; at the half-bit tick it returns to IDLE; no strobes; `data_out` unchanged.
3. Frame 0x3C with stop bit 0, line held low for 3 bit times, then high, then frame 0x11 → one `frame_err` pulse, `data_valid`=0, `data_out`=0x3C; no frame starts while the line is low; 0x11 is then received with `data_valid`.
4. PARITY_EN=1, PARITY_ODD=0: 0x07 with parity bit 1 → `data_valid`; 0x07 with parity bit 0 → `par_err` pulse, no `data_valid`.
5. `rst_n` pulsed low during data bit 4 of 0xF0 → outputs at reset values asynchronously; no strobe; a subsequent 0x55 frame is received correctly.
6. Back-to-back 8N1 frames 0x00 then 0xFF with one stop bit each → two `data_valid` pulses, `data_out` equal to 0x00 then 0xFF, no errors.
